gpio_access_arbiter: RTL and testbench
======================================

// Module: gpio_access_arbiter
// PURPOSE
// - Shares the single-port gpio_ip register interface (sel/write_en/read_en/wdata/rdata)
//   between NUM_REQ independent requesters (e.g. CPU bus bridge, pattern sequencer).
// - Round-robin arbitration, one access in flight at a time, valid/ready request
//   handshake and a one-cycle response pulse per requester. Sits directly in front of gpio_ip.
// PARAMETERS
// - NUM_REQ  2   number of requesters, 2..4
// - DW       32  data width, matches gpio_ip wdata/rdata
// - RD_LAT   1   cycles after the read_en cycle before gpio_rdata is sampled, 0..3
// PORTS
// - clk            in   1           single system clock, all logic on posedge
// - rst            in   1           asynchronous active-low reset
// - req_valid      in   NUM_REQ     per-requester access request
// - req_we         in   NUM_REQ     1 = write, 0 = read; held with req_valid
// - req_wdata      in   NUM_REQ*DW  flattened write data, requester i at [i*DW +: DW]
// - req_ready      out  NUM_REQ     one-cycle accept pulse to the granted requester
// - rsp_valid      out  NUM_REQ     one-cycle completion pulse to the granted requester
// - rsp_rdata      out  DW          read data, shared, qualified by rsp_valid (reads only)
// - busy           out  1           high whenever state != IDLE
// - gpio_sel       out  1           to gpio_ip sel
// - gpio_write_en  out  1           to gpio_ip write_en
// - gpio_read_en   out  1           to gpio_ip read_en
// - gpio_wdata     out  DW          to gpio_ip wdata
// - gpio_rdata     in   DW          from gpio_ip rdata
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; all outputs 0; rr pointer = NUM_REQ-1 so requester 0
//   wins first. Reset mid-access aborts it: no rsp_valid is ever issued for it.
// - FSM: IDLE -> ISSUE -> (WAIT x RD_LAT, reads only) -> RESP -> IDLE. All outputs registered.
// - IDLE: if any req_valid, pick winner g = first set bit searching from ptr+1 upward with
//   wrap; latch g, req_we[g], req_wdata[g]; ptr <= g; go ISSUE. No req_valid: stay IDLE.
// - ISSUE (1 cycle): gpio_sel=1, gpio_write_en=we_l, gpio_read_en=~we_l, gpio_wdata=wdata_l,
//   req_ready[g]=1. Write -> RESP. Read, RD_LAT=0 -> sample gpio_rdata at this edge, RESP.
//   Read, RD_LAT>0 -> WAIT.
// - WAIT: gpio_sel/write_en/read_en=0; counter runs RD_LAT cycles, samples gpio_rdata into
//   rsp_rdata on the last, then RESP.
// - RESP (1 cycle): rsp_valid[g]=1; rsp_rdata = captured data (reads), unchanged (writes).
//   Next IDLE; arbitration re-evaluated from IDLE.
// - Latency: write req_valid sampled (IDLE) -> rsp_valid 2 cycles later; read 2+RD_LAT.
// - Requesters hold req_valid/req_we/req_wdata until req_ready; controller uses latched copies,
//   so an early drop does not cancel the access. req_valid held after req_ready = new request.
// - Simultaneous requests: exactly one granted; others wait; loser gets priority next round,
//   so no requester waits more than NUM_REQ-1 accesses.
// - gpio_wdata retains the last issued value outside ISSUE; gpio_sel never high outside ISSUE.
// - At most one bit of req_ready and of rsp_valid is high in any cycle.
// TESTING
// - Reset then req0 write 32'h0000_0005 -> one ISSUE cycle: sel=1, write_en=1, wdata=5;
//   req_ready[0] same cycle; rsp_valid[0] next cycle; gpio_out=5.
// - req1 read, RD_LAT=1 after above -> read_en one cycle, rsp_valid[1] 3 cycles after
//   request sampled, rsp_rdata=32'h0000_0005.
// - req0 and req1 valid same cycle, held for 4 accesses -> grants 0,1,0,1; never two
//   ready/rsp bits high together.
// - req0 drops req_valid the cycle after IDLE sampled it -> access still completes with
//   latched wdata, rsp_valid[0] issued.
// - rst low during WAIT of a read -> all outputs 0 immediately, no rsp_valid; first access
//   after reset goes to requester 0.
// - Idle 10 cycles with no req_valid -> gpio_sel/write_en/read_en stay 0, busy=0.

Source files
------------

// File: rtl/gpio_access_arbiter.sv
// Round-robin arbiter that shares one gpio_ip register port between NUM_REQ requesters.
// One access in flight at a time; every output comes straight from a flop.
module gpio_access_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DW      = 32,
    parameter int RD_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  busy,
    output logic                  gpio_sel,
    output logic                  gpio_write_en,
    output logic                  gpio_read_en,
    output logic [DW-1:0]         gpio_wdata,
    input  logic [DW-1:0]         gpio_rdata
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       grant_q, grant_d;
    logic                we_q, we_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [1:0]          cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                busy_q, busy_d;
    logic                gpio_sel_q, gpio_sel_d;
    logic                gpio_write_en_q, gpio_write_en_d;
    logic                gpio_read_en_q, gpio_read_en_d;
    logic [DW-1:0]       gpio_wdata_q, gpio_wdata_d;

    logic                pick_found;
    logic [PW-1:0]       pick_idx;
    logic [PW-1:0]       cand;
    logic [NUM_REQ-1:0]  grant_oh;
    logic                issue_d;

    // Search upward from the slot after the last winner, wrapping, so the last winner goes last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    ptr_d   = pick_idx;
                    we_d    = req_we[pick_idx];
                    wdata_d = req_wdata[pick_idx*DW +: DW];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                end else if (RD_LAT == 0) begin
                    rsp_rdata_d = gpio_rdata;
                    state_d     = RESP;
                end else begin
                    cnt_d   = 2'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    rsp_rdata_d = gpio_rdata;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the flops present them during that state.
        grant_oh          = '0;
        grant_oh[grant_d] = 1'b1;
        issue_d           = (state_d == ISSUE);
        gpio_sel_d        = issue_d;
        gpio_write_en_d   = issue_d & we_d;
        gpio_read_en_d    = issue_d & ~we_d;
        gpio_wdata_d      = issue_d ? wdata_d : gpio_wdata_q;
        req_ready_d       = issue_d ? grant_oh : '0;
        rsp_valid_d       = (state_d == RESP) ? grant_oh : '0;
        busy_d            = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            ptr_q           <= PW'(NUM_REQ - 1);
            grant_q         <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            cnt_q           <= '0;
            req_ready_q     <= '0;
            rsp_valid_q     <= '0;
            rsp_rdata_q     <= '0;
            busy_q          <= 1'b0;
            gpio_sel_q      <= 1'b0;
            gpio_write_en_q <= 1'b0;
            gpio_read_en_q  <= 1'b0;
            gpio_wdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            grant_q         <= grant_d;
            we_q            <= we_d;
            wdata_q         <= wdata_d;
            cnt_q           <= cnt_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            busy_q          <= busy_d;
            gpio_sel_q      <= gpio_sel_d;
            gpio_write_en_q <= gpio_write_en_d;
            gpio_read_en_q  <= gpio_read_en_d;
            gpio_wdata_q    <= gpio_wdata_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign busy          = busy_q;
    assign gpio_sel      = gpio_sel_q;
    assign gpio_write_en = gpio_write_en_q;
    assign gpio_read_en  = gpio_read_en_q;
    assign gpio_wdata    = gpio_wdata_q;

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Scoreboard bench for gpio_access_arbiter: stimulus queues expected grants/responses,
// a negedge monitor pops and compares whenever the DUT pulses req_ready or rsp_valid.
module tb_gpio_access_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DW      = 32;
    localparam int RD_LAT  = 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_we = '0;
    logic [NUM_REQ*DW-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DW-1:0]         rsp_rdata;
    logic                  busy;
    logic                  gpio_sel;
    logic                  gpio_write_en;
    logic                  gpio_read_en;
    logic [DW-1:0]         gpio_wdata;
    logic [DW-1:0]         gpio_rdata = '0;
    logic [DW-1:0]         gpio_reg = '0;

    typedef struct {
        int          idx;
        bit          rd;
        logic [31:0] data;
    } rsp_t;

    int   exp_grant[$];
    rsp_t exp_rsp[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   re_cycles = 0;

    gpio_access_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .busy          (busy),
        .gpio_sel      (gpio_sel),
        .gpio_write_en (gpio_write_en),
        .gpio_read_en  (gpio_read_en),
        .gpio_wdata    (gpio_wdata),
        .gpio_rdata    (gpio_rdata)
    );

    always #5 clk = ~clk;

    // Minimal gpio_ip: one register, read data registered (one cycle after read_en).
    always @(posedge clk) begin
        if (gpio_sel && gpio_write_en) gpio_reg <= gpio_wdata;
        if (gpio_sel && gpio_read_en)  gpio_rdata <= gpio_reg;
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor
    int          mon_g;
    rsp_t        mon_r;
    logic [1:0]  mon_oh;
    always @(negedge clk) begin
        if (rst) begin
            if (gpio_read_en) re_cycles++;
            if (req_ready != '0) begin
                check("ready_onehot", 96'($onehot(req_ready)), 96'd1);
                if (exp_grant.size() == 0) begin
                    check("ready_unexpected", 96'(req_ready), 96'd0);
                end else begin
                    mon_g = exp_grant.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_g] = 1'b1;
                    check("grant_order", 96'(req_ready), 96'(mon_oh));
                end
            end
            if (rsp_valid != '0) begin
                check("rsp_onehot", 96'($onehot(rsp_valid)), 96'd1);
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 96'(rsp_valid), 96'd0);
                end else begin
                    mon_r = exp_rsp.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_r.idx] = 1'b1;
                    check("rsp_idx", 96'(rsp_valid), 96'(mon_oh));
                    if (mon_r.rd) check("rsp_rdata", 96'(rsp_rdata), 96'(mon_r.data));
                end
            end
        end
    end

    task automatic drive_req(input int i, input bit we, input logic [31:0] wd);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_wdata[i*DW +: DW] = wd;
    endtask

    task automatic wait_ready(input int i, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!req_ready[i] && cycles < 20);
        if (!req_ready[i]) check("ready_timeout", 96'd0, 96'd1);
    endtask

    task automatic wait_rsp(input int i, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!rsp_valid[i] && cycles < 20);
        if (!rsp_valid[i]) check("rsp_timeout", 96'd0, 96'd1);
    endtask

    task automatic check_all_zero(input string name);
        check(name, 96'({req_ready, rsp_valid, rsp_rdata, busy, gpio_sel,
                         gpio_write_en, gpio_read_en, gpio_wdata}), 96'd0);
    endtask

    initial begin
        int cyc;
        int re0;
        int nready;
        int bad;
        bit seen0, seen1;

        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b1;
        @(negedge clk);

        // Write from requester 0
        exp_grant.push_back(0);
        exp_rsp.push_back('{idx: 0, rd: 1'b0, data: 32'h0});
        drive_req(0, 1'b1, 32'h0000_0005);
        wait_ready(0, cyc);
        check("wr_ready_lat", 96'(cyc), 96'd1);
        check("wr_issue", 96'({gpio_sel, gpio_write_en, gpio_read_en, gpio_wdata}),
              96'({3'b110, 32'h0000_0005}));
        req_valid[0] = 1'b0;
        wait_rsp(0, cyc);
        check("wr_rsp_lat", 96'(cyc), 96'd1);
        @(negedge clk);
        check("wr_gpio_out", 96'(gpio_reg), 96'h5);
        check("wr_idle_busy", 96'(busy), 96'd0);

        // Read from requester 1
        exp_grant.push_back(1);
        exp_rsp.push_back('{idx: 1, rd: 1'b1, data: 32'h0000_0005});
        re0 = re_cycles;
        drive_req(1, 1'b0, 32'h0);
        wait_ready(1, cyc);
        check("rd_issue", 96'({gpio_sel, gpio_write_en, gpio_read_en}), 96'(3'b101));
        req_valid[1] = 1'b0;
        wait_rsp(1, cyc);
        check("rd_rsp_lat", 96'(cyc + 1), 96'(2 + RD_LAT));
        check("rd_en_cycles", 96'(re_cycles - re0), 96'd1);
        @(negedge clk);

        // Both held for four accesses: 0,1,0,1
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_rsp.push_back('{idx: 0, rd: 1'b0, data: 32'h0});
        exp_rsp.push_back('{idx: 1, rd: 1'b1, data: 32'h0000_00A5});
        exp_rsp.push_back('{idx: 0, rd: 1'b0, data: 32'h0});
        exp_rsp.push_back('{idx: 1, rd: 1'b1, data: 32'h0000_00A5});
        drive_req(0, 1'b1, 32'h0000_00A5);
        drive_req(1, 1'b0, 32'h0);
        nready = 0;
        for (int c = 0; c < 40 && nready < 4; c++) begin
            @(negedge clk);
            if (req_ready != '0) nready++;
        end
        req_valid = '0;
        check("held_ready_count", 96'(nready), 96'd4);
        repeat (4) @(negedge clk);

        // Early drop: wdata latched at the IDLE edge
        exp_grant.push_back(0);
        exp_rsp.push_back('{idx: 0, rd: 1'b0, data: 32'h0});
        drive_req(0, 1'b1, 32'h0000_0077);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        req_wdata[31:0] = 32'hDEAD_BEEF;
        @(negedge clk);
        check("drop_ready", 96'(req_ready), 96'(2'b01));
        check("drop_wdata", 96'(gpio_wdata), 96'h77);
        wait_rsp(0, cyc);
        check("drop_rsp_lat", 96'(cyc), 96'd1);
        @(negedge clk);
        check("drop_gpio_out", 96'(gpio_reg), 96'h77);

        // Reset during WAIT of a read: no response, pointer restored
        exp_grant.push_back(1);
        drive_req(1, 1'b0, 32'h0);
        wait_ready(1, cyc);
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("wait_state", 96'({busy, gpio_sel, gpio_read_en}), 96'(3'b100));
        rst = 1'b0;
        #1;
        check_all_zero("midreset_outputs");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset_quiet");
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_rsp.push_back('{idx: 0, rd: 1'b0, data: 32'h0});
        exp_rsp.push_back('{idx: 1, rd: 1'b0, data: 32'h0});
        drive_req(0, 1'b1, 32'h0000_0011);
        drive_req(1, 1'b1, 32'h0000_0022);
        seen0 = 1'b0;
        seen1 = 1'b0;
        for (int c = 0; c < 30 && !(seen0 && seen1); c++) begin
            @(negedge clk);
            if (req_ready[0]) begin seen0 = 1'b1; req_valid[0] = 1'b0; end
            if (req_ready[1]) begin seen1 = 1'b1; req_valid[1] = 1'b0; end
        end
        check("post_reset_both_served", 96'({seen0, seen1}), 96'(2'b11));
        repeat (3) @(negedge clk);
        check("post_reset_gpio_out", 96'(gpio_reg), 96'h22);

        // Idle with no requests
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (gpio_sel || gpio_write_en || gpio_read_en || busy) bad++;
        end
        check("idle_quiet", 96'(bad), 96'd0);

        check("grant_queue_empty", 96'(exp_grant.size()), 96'd0);
        check("rsp_queue_empty", 96'(exp_rsp.size()), 96'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
